ring_drain_tx: RTL and testbench

- Downstream consumer of the LPC sniffer capture ring.
- When the ring reports non-empty, it reads one captured record from the ring's record RAM at the ring's read address.
- It serialises the record, optionally preceded by a sync header byte, onto a byte-wide valid/ready stream that feeds the UART transmitter.
- It then issues one read_done pulse so the ring advances its read pointer.

---
 rtl/lpc_sniffer_pkg.sv | 23 ++
 rtl/ring_drain_tx_sync2.sv | 27 ++
 rtl/ring_drain_tx.sv | 147 ++++++++++++++
 tb/tb_ring_drain_tx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer capture path: drain FSM state
// encoding and default record geometry.
package lpc_sniffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_HDR   = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5,
    ST_HOLD  = 3'd6
  } state_e;

  localparam int         REC_W_DEFAULT    = 48;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  // Number of bytes in a record of width w bits.
  function automatic int rec_bytes(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/ring_drain_tx_sync2.sv
// Two-flop synchroniser with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ring_drain_tx.sv
// Drains one record at a time from the capture ring and serialises it,
// MSB byte first and optionally behind a sync header, onto a byte stream.
//
// state | meaning
// IDLE  | waiting for synchronised empty to drop; captures read address
// FETCH | RAM read enable asserted for one cycle
// LATCH | RAM data captured into the shift register, first byte presented
// HDR   | header byte presented, waiting for handshake
// SEND  | record bytes presented MSB first, one per handshake
// DONE  | single-cycle read_done pulse to advance the ring
// HOLD  | guard time so ring pointer/empty settle through the synchroniser
module ring_drain_tx
  import lpc_sniffer_pkg::*;
#(
  parameter int         BITS     = 5,
  parameter int         DATA_W   = REC_W_DEFAULT,
  parameter int         HDR_EN   = 1,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT,
  parameter int         GUARD    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic [BITS-1:0]   read_addr,
  output logic              ram_rd_en,
  output logic [BITS-1:0]   ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              read_done,
  output logic              busy
);

  localparam int NBYTES = rec_bytes(DATA_W);
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int GW     = $clog2(GUARD + 1);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] FETCH = ST_FETCH;
  localparam logic [2:0] LATCH = ST_LATCH;
  localparam logic [2:0] HDR   = ST_HDR;
  localparam logic [2:0] SEND  = ST_SEND;
  localparam logic [2:0] DONE  = ST_DONE;
  localparam logic [2:0] HOLD  = ST_HOLD;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [GW-1:0]     r_guard;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_rd_en;
  logic [BITS-1:0]   r_rd_addr;
  logic              r_read_done;

  logic              w_empty_s;
  logic              w_hs;
  logic [DATA_W-1:0] w_shift_nxt;

  sync2 #(.RST_VAL(1'b1)) u_empty_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (empty),
    .o_q   (w_empty_s)
  );

  assign w_hs        = r_tx_valid & tx_ready;
  assign w_shift_nxt = r_shift << 8;

  // Drain sequencer; all stream outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_guard     <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_read_done <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_read_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty_s) begin
            r_rd_addr <= read_addr;
            r_rd_en   <= 1'b1;
            r_state   <= FETCH;
          end
        end
        FETCH: r_state <= LATCH;
        LATCH: begin
          r_shift    <= ram_rd_data;
          r_cnt      <= CW'(NBYTES);
          r_tx_valid <= 1'b1;
          if (HDR_EN != 0) begin
            r_tx_data <= HDR_BYTE;
            r_state   <= HDR;
          end else begin
            r_tx_data <= ram_rd_data[DATA_W-1 -: 8];
            r_state   <= SEND;
          end
        end
        HDR: begin
          if (w_hs) begin
            r_tx_data <= r_shift[DATA_W-1 -: 8];
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
              // tx_valid drops as read_done rises, so they never overlap.
              r_tx_valid  <= 1'b0;
              r_read_done <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_tx_data <= w_shift_nxt[DATA_W-1 -: 8];
            end
          end
        end
        DONE: begin
          r_guard <= GW'(GUARD - 1);
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_guard == '0) r_state <= IDLE;
          else               r_guard <= r_guard - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_rd_addr;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign read_done   = r_read_done;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ring_drain_tx.sv
// Scoreboard bench for ring_drain_tx: a default 48-bit/header instance fed
// by a small ring model, plus a 16-bit no-header instance.
module tb_ring_drain_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default instance
  logic        empty;
  logic [4:0]  read_addr;
  logic        ram_rd_en;
  logic [4:0]  ram_rd_addr;
  logic [47:0] ram_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        read_done;
  logic        busy;

  // 16-bit, no-header instance
  logic        empty16;
  logic [4:0]  read_addr16;
  logic        rd_en16;
  logic [4:0]  rd_addr16;
  logic [15:0] rdata16;
  logic [7:0]  tx_data16;
  logic        tx_valid16;
  logic        tx_ready16;
  logic        done16;
  logic        busy16;

  ring_drain_tx dut (
    .clk(clk), .reset(reset), .empty(empty), .read_addr(read_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .read_done(read_done), .busy(busy)
  );

  ring_drain_tx #(.BITS(5), .DATA_W(16), .HDR_EN(0), .HDR_BYTE(8'hA5), .GUARD(3)) dut16 (
    .clk(clk), .reset(reset), .empty(empty16), .read_addr(read_addr16),
    .ram_rd_en(rd_en16), .ram_rd_addr(rd_addr16), .ram_rd_data(rdata16),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .read_done(done16), .busy(busy16)
  );

  // Ring model: write pointer advanced by stimulus, read pointer by read_done.
  logic [47:0] ram [0:31];
  logic [4:0]  ring_addr [0:7];
  int wp = 0;
  int rp = 0;
  assign empty     = (wp == rp);
  assign read_addr = ring_addr[rp[2:0]];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  always @(posedge clk) if (read_done) rp <= rp + 1;

  logic [15:0] mem16;
  int wp16 = 0;
  int rp16 = 0;
  assign empty16     = (wp16 == rp16);
  assign read_addr16 = 5'd9;
  assign tx_ready16  = 1'b1;
  always @(posedge clk) if (rd_en16) rdata16 <= mem16;
  always @(posedge clk) if (done16) rp16 <= rp16 + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: bit 8 set marks an expected read_done pulse.
  logic [8:0] exp_q[$];
  logic [8:0] exp16_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int rd16_cnt = 0;
  int last_rd_cyc = 0;
  int rd_gap = 0;

  int bp_mode = 0;
  logic rdy_val = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event, nothing queued (t=%0t)", name, $time);
  endtask

  task automatic push_exp(input logic [47:0] d);
    exp_q.push_back(9'h0A5);
    for (int b = 5; b >= 0; b--) exp_q.push_back({1'b0, d[b*8 +: 8]});
    exp_q.push_back(9'h100);
  endtask

  task automatic push_rec(input logic [4:0] a, input logic [47:0] d);
    ram[a] = d;
    ring_addr[wp % 8] = a;
    push_exp(d);
    wp = wp + 1;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= maxc) begin
      n_bad++;
      $display("FAIL %s: timeout, %0d items still queued, busy=%0b", name, exp_q.size(), busy);
    end
  endtask

  // Ready driver, changes away from the sampling edge.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode != 0) tx_ready = ((cyc % 3) == 0);
      else              tx_ready = rdy_val;
    end
  end

  // Monitor for the default instance.
  initial begin : mon_a
    logic pv, pr;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 1'b0; pr = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, pd);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) fail_event("tx_byte");
          else begin
            e = exp_q.pop_front();
            chk("tx_byte", {1'b0, tx_data}, e);
            hs_cnt++;
          end
        end
        if (read_done) begin
          chk("read_done_vs_valid", tx_valid, 0);
          if (exp_q.size() == 0) fail_event("read_done");
          else begin
            e = exp_q.pop_front();
            chk("read_done_order", {read_done, 8'h00}, e);
          end
          rd_gap = cyc - last_rd_cyc;
          last_rd_cyc = cyc;
          rd_cnt++;
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
      end
    end
  end

  // Monitor for the 16-bit instance.
  initial begin : mon_b
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_valid16 && tx_ready16) begin
          if (exp16_q.size() == 0) fail_event("tx16_byte");
          else begin
            e = exp16_q.pop_front();
            chk("tx16_byte", {1'b0, tx_data16}, e);
          end
        end
        if (done16) begin
          chk("read_done16_vs_valid", tx_valid16, 0);
          if (exp16_q.size() == 0) fail_event("read_done16");
          else begin
            e = exp16_q.pop_front();
            chk("read_done16_order", {done16, 8'h00}, e);
          end
          rd16_cnt++;
        end
      end
    end
  end

  initial begin : main
    int k, first, base, rd_save;
    logic seen_en, seen_v, seen_rd, seen_busy;
    reset = 1'b1;
    mem16 = 16'h0000;
    for (int i = 0; i < 32; i++) ram[i] = 48'h0;
    for (int i = 0; i < 8; i++) ring_addr[i] = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ram_rd_en", ram_rd_en, 0);
    chk("rst_ram_rd_addr", ram_rd_addr, 5'd0);
    chk("rst_read_done", read_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy16", busy16, 0);
    reset = 1'b0;

    // Empty held high: nothing happens
    seen_en = 0; seen_v = 0; seen_rd = 0; seen_busy = 0;
    repeat (100) begin
      @(negedge clk);
      seen_en   |= ram_rd_en;
      seen_v    |= tx_valid;
      seen_rd   |= read_done;
      seen_busy |= busy;
    end
    chk("idle_ram_rd_en", seen_en, 0);
    chk("idle_tx_valid", seen_v, 0);
    chk("idle_read_done", seen_rd, 0);
    chk("idle_busy", seen_busy, 0);

    // Single record with header, latency and address
    push_rec(5'd5, 48'h123456789ABC);
    first = 0;
    for (k = 1; k <= 10 && first == 0; k++) begin
      @(posedge clk);
      #1;
      if (tx_valid) first = k;
    end
    chk("first_valid_edge", first, 5);
    chk("ram_rd_addr", ram_rd_addr, 5'd5);
    wait_drain(200, "single_record");
    chk("read_done_count_1", rd_cnt, 1);

    // Backpressure 1-in-3
    bp_mode = 1;
    push_rec(5'd5, 48'h123456789ABC);
    wait_drain(400, "backpressure");
    bp_mode = 0;
    chk("read_done_count_2", rd_cnt, 2);

    // Back-to-back with address wrap
    push_rec(5'd31, 48'h000000000001);
    push_rec(5'd0,  48'hFFFFFFFFFFFF);
    k = 0;
    while (rd_cnt < 4 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("b2b_two_done", rd_cnt, 4);
    chk("b2b_gap", rd_gap, 14);
    chk("b2b_gap_min", (rd_gap >= 11), 1);
    chk("b2b_wrap_addr", ram_rd_addr, 5'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 20);
    chk("idle_after_guard", k, 4);
    wait_drain(50, "b2b_drain");

    // 16-bit record, no header
    mem16 = 16'hBEEF;
    exp16_q.push_back(9'h0BE);
    exp16_q.push_back(9'h0EF);
    exp16_q.push_back(9'h100);
    wp16 = wp16 + 1;
    k = 0;
    while ((exp16_q.size() != 0 || busy16) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rec16_drained", (k < 100), 1);
    chk("rec16_done_count", rd16_cnt, 1);
    chk("rec16_addr", rd_addr16, 5'd9);

    // Reset after the second byte; record must resend from the header
    push_rec(5'd7, 48'h123456789ABC);
    base = hs_cnt;
    k = 0;
    while (hs_cnt < base + 2 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reset_reach_byte2", (hs_cnt >= base + 2), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_read_done", read_done, 0);
    chk("midrst_busy", busy, 0);
    rd_save = rd_cnt;
    exp_q.delete();
    push_exp(48'h123456789ABC);
    @(negedge clk);
    reset = 1'b0;
    wait_drain(200, "resend_after_reset");
    chk("resend_done_count", rd_cnt, rd_save + 1);

    // tx_ready stuck low: stall without losing the record
    rdy_val = 1'b0;
    push_rec(5'd3, 48'hCAFE0102F00D);
    rd_save = rd_cnt;
    repeat (60) @(negedge clk);
    chk("stuck_tx_valid", tx_valid, 1);
    chk("stuck_tx_data", tx_data, 8'hA5);
    chk("stuck_no_done", rd_cnt, rd_save);
    rdy_val = 1'b1;
    wait_drain(200, "stuck_release");
    chk("stuck_done_count", rd_cnt, rd_save + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
